// File: rtl/pa_session_ctrl.sv
// pa_session_ctrl: session controller that sequences one privacy-amplification
// block at a time. It validates the key length, pulses the PA core start,
// counts secret-key writes and watches for finish, failure or link loss. It
// also ping-pongs the reconciled-key bank between blocks.
// Optional feature: define PA_WATCHDOG_EN to add a RUN watchdog that ends a
// stalled block with err_code 4 after TIMEOUT_CYCLES cycles.
module pa_session_ctrl #(
    parameter logic [31:0] MAX_KEY_LEN    = 32'd1048576,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_status,
    input  logic        start_switch,
    input  logic [31:0] secretkey_length,
    input  logic        pa_finish,
    input  logic        pa_fail,
    input  logic        key_wr,
    output logic        pa_start,
    output logic        pa_addr_index,
    output logic        busy,
    output logic        session_done,
    output logic [2:0]  err_code,
    output logic [15:0] block_cnt,
    output logic [15:0] key_word_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        FAIL  = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LENGTH  = 3'd1;
    localparam logic [2:0] ERR_PA_FAIL = 3'd2;
    localparam logic [2:0] ERR_LINK    = 3'd3;
`ifdef PA_WATCHDOG_EN
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
`endif

    state_t      state_q, state_d;
    logic        start_prev_q;
    logic        addr_index_q, addr_index_d;
    logic [15:0] block_cnt_q, block_cnt_d;
    logic [15:0] key_word_cnt_q, key_word_cnt_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        start_rise;
    logic        length_ok;

`ifdef PA_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_expired;
    assign wdog_expired = (wdog_q == (TIMEOUT_CYCLES - 32'd1));
`endif

    // The previous start_switch value is tracked in every state, so a level
    // held high across a whole block never reads as a new request.
    assign start_rise = start_switch & ~start_prev_q;

    // A length is usable only when it is nonzero, whole 64-bit words and
    // within the configured maximum.
    assign length_ok = (secretkey_length != 32'd0) &&
                       (secretkey_length[5:0] == 6'd0) &&
                       (secretkey_length <= MAX_KEY_LEN);

    // State and datapath registers; reset aborts everything without pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            start_prev_q   <= 1'b0;
            addr_index_q   <= 1'b0;
            block_cnt_q    <= 16'd0;
            key_word_cnt_q <= 16'd0;
            err_code_q     <= ERR_NONE;
`ifdef PA_WATCHDOG_EN
            wdog_q         <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            start_prev_q   <= start_switch;
            addr_index_q   <= addr_index_d;
            block_cnt_q    <= block_cnt_d;
            key_word_cnt_q <= key_word_cnt_d;
            err_code_q     <= err_code_d;
`ifdef PA_WATCHDOG_EN
            wdog_q         <= wdog_d;
`endif
        end
    end

    // Next-state and datapath updates; every register holds unless its state says otherwise.
    always_comb begin
        state_d        = state_q;
        addr_index_d   = addr_index_q;
        block_cnt_d    = block_cnt_q;
        key_word_cnt_d = key_word_cnt_q;
        err_code_d     = err_code_q;
`ifdef PA_WATCHDOG_EN
        wdog_d         = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_rise && link_status) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (length_ok) begin
                    state_d = START;
                end else begin
                    state_d    = FAIL;
                    err_code_d = ERR_LENGTH;
                end
            end
            START: begin
                key_word_cnt_d = 16'd0;
`ifdef PA_WATCHDOG_EN
                wdog_d         = 32'd0;
`endif
                state_d        = RUN;
            end
            RUN: begin
                if (key_wr && (key_word_cnt_q != 16'hFFFF)) begin
                    key_word_cnt_d = key_word_cnt_q + 16'd1;
                end
`ifdef PA_WATCHDOG_EN
                wdog_d = wdog_q + 32'd1;
`endif
                if (pa_fail) begin
                    state_d    = FAIL;
                    err_code_d = ERR_PA_FAIL;
                end else if (pa_finish) begin
                    state_d = DONE;
                end else if (!link_status) begin
                    state_d    = FAIL;
                    err_code_d = ERR_LINK;
                end
`ifdef PA_WATCHDOG_EN
                else if (wdog_expired) begin
                    state_d    = FAIL;
                    err_code_d = ERR_TIMEOUT;
                end
`endif
            end
            DONE: begin
                addr_index_d = ~addr_index_q;
                block_cnt_d  = block_cnt_q + 16'd1;
                state_d      = IDLE;
            end
            FAIL: begin
                if (!start_switch) begin
                    state_d    = IDLE;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pa_start      = (state_q == START);
    assign busy          = (state_q == CHECK) || (state_q == START) || (state_q == RUN);
    assign session_done  = (state_q == DONE);
    assign pa_addr_index = addr_index_q;
    assign block_cnt     = block_cnt_q;
    assign key_word_cnt  = key_word_cnt_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_pa_session_ctrl.sv
// Directed testbench for pa_session_ctrl. The watchdog expectation follows
// PA_WATCHDOG_EN so the same bench covers both builds.
module tb_pa_session_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_status;
    logic        start_switch;
    logic [31:0] secretkey_length;
    logic        pa_finish;
    logic        pa_fail;
    logic        key_wr;
    logic        pa_start;
    logic        pa_addr_index;
    logic        busy;
    logic        session_done;
    logic [2:0]  err_code;
    logic [15:0] block_cnt;
    logic [15:0] key_word_cnt;

    int checks = 0;
    int errors = 0;

    pa_session_ctrl #(
        .MAX_KEY_LEN   (32'd1048576),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .link_status     (link_status),
        .start_switch    (start_switch),
        .secretkey_length(secretkey_length),
        .pa_finish       (pa_finish),
        .pa_fail         (pa_fail),
        .key_wr          (key_wr),
        .pa_start        (pa_start),
        .pa_addr_index   (pa_addr_index),
        .busy            (busy),
        .session_done    (session_done),
        .err_code        (err_code),
        .block_cnt       (block_cnt),
        .key_word_cnt    (key_word_cnt)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Advance n cycles; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a fresh start edge from IDLE and walk CHECK -> START -> RUN.
    task automatic launch(input logic [31:0] len);
        secretkey_length = len;
        start_switch = 1'b0;
        tick(1);
        start_switch = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0h expected 0", busy); end
        checks++; if (pa_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_pa_start got %0h expected 0", pa_start); end
        checks++; if (session_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0h expected 0", session_done); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_err got %0h expected 0", err_code); end
        checks++; if (pa_addr_index !== 1'b0) begin errors++; $display("[TB] FAIL reset_index got %0h expected 0", pa_addr_index); end
        checks++; if (block_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_block_cnt got %0h expected 0", block_cnt); end
        checks++; if (key_word_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_key_cnt got %0h expected 0", key_word_cnt); end
    endtask

    task automatic test_normal_block();
        int done_pulses;
        done_pulses = 0;
        secretkey_length = 32'd4096;
        start_switch = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b1 || pa_start !== 1'b0) begin errors++; $display("[TB] FAIL check_state busy=%0h pa_start=%0h expected 1/0", busy, pa_start); end
        tick(1);
        checks++; if (pa_start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse got %0h expected 1", pa_start); end
        checks++; if (pa_addr_index !== 1'b0) begin errors++; $display("[TB] FAIL start_index got %0h expected 0", pa_addr_index); end
        tick(1);
        checks++; if (pa_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL run_entry pa_start=%0h busy=%0h expected 0/1", pa_start, busy); end
        for (int i = 0; i < 199; i++) begin
            key_wr = (i < 64);
            tick(1);
            if (session_done === 1'b1) done_pulses++;
        end
        key_wr = 1'b0;
        checks++; if (key_word_cnt !== 16'd64) begin errors++; $display("[TB] FAIL run_key_cnt got %0d expected 64", key_word_cnt); end
        pa_finish = 1'b1;
        tick(1);
        pa_finish = 1'b0;
        if (session_done === 1'b1) done_pulses++;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (session_done === 1'b1) done_pulses++;
        end
        checks++; if (done_pulses !== 1) begin errors++; $display("[TB] FAIL done_pulses got %0d expected 1", done_pulses); end
        checks++; if (block_cnt !== 16'd1) begin errors++; $display("[TB] FAIL block_cnt got %0d expected 1", block_cnt); end
        checks++; if (key_word_cnt !== 16'd64) begin errors++; $display("[TB] FAIL key_word_cnt got %0d expected 64", key_word_cnt); end
        checks++; if (pa_addr_index !== 1'b1) begin errors++; $display("[TB] FAIL index_toggle got %0h expected 1", pa_addr_index); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_start_retrigger busy=%0h expected 0", busy); end
        start_switch = 1'b0;
        tick(1);
    endtask

    task automatic test_bad_length();
        logic [31:0] bad_lens [2];
        int start_seen;
        bad_lens[0] = 32'd4100;
        bad_lens[1] = 32'd0;
        for (int k = 0; k < 2; k++) begin
            start_seen = 0;
            secretkey_length = bad_lens[k];
            start_switch = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick(1);
                if (pa_start === 1'b1) start_seen++;
            end
            checks++; if (err_code !== 3'd1) begin errors++; $display("[TB] FAIL bad_len_err len=%0d got %0h expected 1", bad_lens[k], err_code); end
            checks++; if (start_seen !== 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bad_len_no_start starts=%0d busy=%0h expected 0/0", start_seen, busy); end
            start_switch = 1'b0;
            tick(1);
            checks++; if (err_code !== 3'd0) begin errors++; $display("[TB] FAIL bad_len_clear got %0h expected 0", err_code); end
            tick(1);
        end
        checks++; if (block_cnt !== 16'd1 || pa_addr_index !== 1'b1) begin errors++; $display("[TB] FAIL bad_len_keep cnt=%0d idx=%0h expected 1/1", block_cnt, pa_addr_index); end
    endtask

    task automatic test_fail_priority();
        launch(32'd4096);
        tick(3);
        pa_fail = 1'b1;
        pa_finish = 1'b1;
        tick(1);
        pa_fail = 1'b0;
        pa_finish = 1'b0;
        checks++; if (err_code !== 3'd2) begin errors++; $display("[TB] FAIL prio_err got %0h expected 2", err_code); end
        checks++; if (session_done !== 1'b0) begin errors++; $display("[TB] FAIL prio_done got %0h expected 0", session_done); end
        tick(2);
        checks++; if (block_cnt !== 16'd1 || err_code !== 3'd2) begin errors++; $display("[TB] FAIL prio_hold cnt=%0d err=%0h expected 1/2", block_cnt, err_code); end
        start_switch = 1'b0;
        tick(1);
        checks++; if (err_code !== 3'd0) begin errors++; $display("[TB] FAIL prio_clear got %0h expected 0", err_code); end
    endtask

    task automatic test_link_loss();
        launch(32'd4096);
        tick(5);
        link_status = 1'b0;
        tick(1);
        checks++; if (err_code !== 3'd3 || busy !== 1'b0) begin errors++; $display("[TB] FAIL link_err err=%0h busy=%0h expected 3/0", err_code, busy); end
        start_switch = 1'b0;
        tick(1);
        start_switch = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b0 || err_code !== 3'd0) begin errors++; $display("[TB] FAIL link_down_edge busy=%0h err=%0h expected 0/0", busy, err_code); end
        start_switch = 1'b0;
        link_status = 1'b1;
        tick(1);
    endtask

    task automatic test_watchdog();
        launch(32'd4096);
        tick(99);
        checks++; if (busy !== 1'b1 || err_code !== 3'd0) begin errors++; $display("[TB] FAIL wdog_early busy=%0h err=%0h expected 1/0", busy, err_code); end
        tick(1);
`ifdef PA_WATCHDOG_EN
        checks++; if (err_code !== 3'd4 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wdog_expire err=%0h busy=%0h expected 4/0", err_code, busy); end
        start_switch = 1'b0;
        tick(1);
`else
        checks++; if (err_code !== 3'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wdog_absent err=%0h busy=%0h expected 0/1", err_code, busy); end
        start_switch = 1'b0;
        pa_fail = 1'b1;
        tick(1);
        pa_fail = 1'b0;
        tick(1);
`endif
        checks++; if (busy !== 1'b0 || err_code !== 3'd0 || block_cnt !== 16'd1) begin errors++; $display("[TB] FAIL wdog_exit busy=%0h err=%0h cnt=%0d expected 0/0/1", busy, err_code, block_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 2; b++) begin
            launch(32'd64);
            pa_finish = 1'b1;
            tick(1);
            pa_finish = 1'b0;
            tick(1);
        end
        checks++; if (block_cnt !== 16'd3) begin errors++; $display("[TB] FAIL b2b_cnt got %0d expected 3", block_cnt); end
        checks++; if (pa_addr_index !== 1'b1) begin errors++; $display("[TB] FAIL b2b_index got %0h expected 1", pa_addr_index); end
    endtask

    task automatic test_reset_mid_run();
        launch(32'd4096);
        key_wr = 1'b1;
        tick(3);
        key_wr = 1'b0;
        rst = 1'b1;
        start_switch = 1'b0;
        tick(1);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || pa_start !== 1'b0 || session_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_ctrl busy=%0h start=%0h done=%0h expected 0/0/0", busy, pa_start, session_done); end
        checks++; if (block_cnt !== 16'd0 || key_word_cnt !== 16'd0 || pa_addr_index !== 1'b0 || err_code !== 3'd0) begin errors++; $display("[TB] FAIL rst_run_data cnt=%0d kw=%0d idx=%0h err=%0h expected 0/0/0/0", block_cnt, key_word_cnt, pa_addr_index, err_code); end
        pa_finish = 1'b1;
        tick(1);
        pa_finish = 1'b0;
        tick(1);
        checks++; if (session_done !== 1'b0 || block_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_late_finish done=%0h cnt=%0d busy=%0h expected 0/0/0", session_done, block_cnt, busy); end
    endtask

    initial begin
        rst = 1'b1;
        link_status = 1'b1;
        start_switch = 1'b0;
        secretkey_length = 32'd0;
        pa_finish = 1'b0;
        pa_fail = 1'b0;
        key_wr = 1'b0;
        test_reset();
        test_normal_block();
        test_bad_length();
        test_fail_priority();
        test_link_loss();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
